touch_sample_capture: RTL and testbench
=======================================

TOUCH_SAMPLE_CAPTURE -- requirements
Module: touch_sample_capture

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 en  input  1  serial-capture window from the touch command sequencer; high during ADC data bit times.
REQ-005 din  input  1  touch ADC serial data out, MSB first, valid at each rising clk while en=1.
REQ-006 x_strobe  input  1  level from the sequencer; its rising edge marks the last captured byte as X.
REQ-007 y_strobe  input  1  level from the sequencer; its rising edge marks the last captured byte as Y.
REQ-008 pen_irq_n  input  1  touch panel pen interrupt, active-low (0 = touched).
REQ-009 x_pos  output  8  reported X coordinate.
REQ-010 y_pos  output  8  reported Y coordinate.
REQ-011 pos_valid  output  1  coordinate pair available.
REQ-012 pos_ready  input  1  consumer accepts the pair when pos_valid=1 and pos_ready=1 on the same edge.
REQ-013 overrun  output  1  sticky flag: a completed pair was dropped because the output was still occupied.

Function
REQ-014 Shifter SHALL shift din into an 8-bit register, MSB first, on every edge with en=1; bit counter 0..8, saturating at 8; extra bits beyond 8 ignored.
REQ-015 A byte SHALL be complete when the counter reaches 8; on en falling with counter<8, the partial byte SHALL be discarded and the counter cleared.
REQ-016 Rising en SHALL restart the counter at 0 and clear the byte-complete flag.
REQ-017 Strobe edges SHALL be detected against a registered copy of each strobe (current=1, previous=0); level-held strobes produce exactly one event.
REQ-018 FSM states: IDLE, HAVE_X. IDLE + x edge with complete byte -> latch x_hold, go HAVE_X. IDLE + x edge without complete byte -> stay IDLE. y edge in IDLE -> ignored.
REQ-019 HAVE_X + y edge with complete byte -> pair complete, go IDLE. HAVE_X + x edge with complete byte -> replace x_hold, stay HAVE_X. HAVE_X + y edge without complete byte -> discard x_hold, go IDLE.
REQ-020 On pair completion with pen_irq_n=1, the pair SHALL be discarded (pen-up filter).
REQ-021 On pair completion with pen_irq_n=0 and pos_valid=0 (or being accepted the same edge), x_pos/y_pos SHALL load and pos_valid SHALL be 1 after that same edge (zero added latency from the y edge).
REQ-022 If pos_valid=1 and pos_ready=0 when a pair completes, the new pair SHALL be dropped, x_pos/y_pos held, and overrun set.
REQ-023 x_pos/y_pos SHALL stay stable while pos_valid=1; pos_valid clears on acceptance unless a new pair loads on that edge.
REQ-024 overrun SHALL clear on the edge of the next accepted transfer.
REQ-025 Simultaneous x and y edges SHALL be treated as y edge only.

Reset
REQ-026 With rst_n=0 at an edge: state IDLE, shifter/counter/hold = 0, strobe history = 0, x_pos=0, y_pos=0, pos_valid=0, overrun=0; mid-frame reset discards all partial data.

Configuration
REQ-027 With TOUCH_AVG_EN defined, completed (pen-down) pairs SHALL accumulate in 10-bit sums; every 4th pair outputs sum>>2 per axis and clears the sums; pen-up discard also clears sums and pair count.
REQ-028 Without TOUCH_AVG_EN, every accepted pair SHALL be output directly per REQ-021.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, SAMPLE_W=8, and AVG_DEPTH=4.
REQ-030 The serial shifter (REQ-014..016) SHALL be a sub-module named touch_serial_shift.

Verification
REQ-031 en high 8 cycles din=1,0,1,0,0,1,1,0; x rise; same with 0x3C; y rise; pen_irq_n=0; pos_ready=1 -> x_pos=0xA6, y_pos=0x3C, pos_valid=1 for one cycle.
REQ-032 en high only 5 cycles then x rise -> no latch; FSM stays IDLE; pos_valid stays 0.
REQ-033 Two full pairs with pos_ready=0 -> first pair held, overrun=1; assert pos_ready -> pair accepted, overrun=0.
REQ-034 Full pair with pen_irq_n=1 -> pos_valid stays 0, overrun stays 0.
REQ-035 rst_n=0 after 4 bits shifted, then a full pair -> output reflects only post-reset bytes.
REQ-036 TOUCH_AVG_EN: X bytes 0x10,0x20,0x30,0x40, Y fixed 0x80 -> one output x_pos=0x28, y_pos=0x80 after 4th pair.

Source files
------------

// File: rtl/touch_sample_capture_pkg.sv
// Shared definitions for the touch-panel serial sample capture block:
// sample widths, averaging depth, FSM state encoding and the coordinate pair type.
package touch_sample_capture_pkg;

  localparam int SAMPLE_W  = 8;
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);
  localparam int SUM_W     = SAMPLE_W + AVG_SHIFT;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_HAVE_X = 1'b1;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t x;
    sample_t y;
  } pos_pair_t;

  // Mean of AVG_DEPTH samples; the sum is wide enough that truncation is exact.
  function automatic sample_t avg_of(input logic [SUM_W-1:0] sum);
    return sample_t'(sum >> AVG_SHIFT);
  endfunction

endpackage

// File: rtl/touch_sample_capture_if.sv
// Sequencer-side capture inputs and consumer-side coordinate handshake.
// The slave modport is the capture block; master is whoever drives it.
interface touch_sample_capture_if;
  import touch_sample_capture_pkg::*;

  logic    en;
  logic    din;
  logic    x_strobe;
  logic    y_strobe;
  logic    pen_irq_n;
  sample_t x_pos;
  sample_t y_pos;
  logic    pos_valid;
  logic    pos_ready;
  logic    overrun;

  modport slave (
    input  en, din, x_strobe, y_strobe, pen_irq_n, pos_ready,
    output x_pos, y_pos, pos_valid, overrun
  );

  modport master (
    output en, din, x_strobe, y_strobe, pen_irq_n, pos_ready,
    input  x_pos, y_pos, pos_valid, overrun
  );

endinterface

// File: rtl/touch_serial_shift.sv
// MSB-first serial deserialiser for the touch ADC data line. byte_done stays
// high from the 8th bit until the next capture window opens.
module touch_serial_shift
  import touch_sample_capture_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] data,
  output logic         byte_done
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(W);

  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             en_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      en_d  <= 1'b0;
    end else begin
      en_d <= en;
      if (en && !en_d) begin
        // A fresh window restarts the count; this edge already carries bit 0.
        shreg <= {shreg[W-2:0], din};
        cnt   <= CNT_W'(1);
      end else if (en) begin
        if (cnt != FULL) begin
          shreg <= {shreg[W-2:0], din};
          cnt   <= cnt + CNT_W'(1);
        end
      end else if (en_d && (cnt != FULL)) begin
        shreg <= '0;
        cnt   <= '0;
      end
    end
  end

  assign data      = shreg;
  assign byte_done = (cnt == FULL);

endmodule

// File: rtl/touch_sample_capture.sv
// Touch coordinate capture: deserialises ADC bytes, pairs them into X/Y via the
// sequencer strobes and hands them out on a valid/ready port. Define
// TOUCH_AVG_EN to report the mean of every AVG_DEPTH pen-down pairs instead.
module touch_sample_capture
  import touch_sample_capture_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  touch_sample_capture_if.slave bus
);

  sample_t   shift_data;
  logic      byte_done;

  touch_serial_shift #(.W(SAMPLE_W)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .din       (bus.din),
    .data      (shift_data),
    .byte_done (byte_done)
  );

  // ---------------- strobe edge detection ----------------
  logic x_prev, y_prev;
  logic x_edge, y_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_prev <= 1'b0;
      y_prev <= 1'b0;
    end else begin
      x_prev <= bus.x_strobe;
      y_prev <= bus.y_strobe;
    end
  end

  assign x_edge = bus.x_strobe & ~x_prev;
  assign y_edge = bus.y_strobe & ~y_prev;

  // ---------------- X/Y pairing FSM ----------------
  logic [0:0] state, state_nx;
  sample_t    x_hold, x_hold_nx;
  logic       pair_done;
  pos_pair_t  new_pair;

  // NOTE: every combinational output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    x_hold_nx = x_hold;
    pair_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!y_edge && x_edge && byte_done) begin
          x_hold_nx = shift_data;
          state_nx  = ST_HAVE_X;
        end
      end
      ST_HAVE_X: begin
        // A y edge wins over a coincident x edge.
        if (y_edge) begin
          state_nx = ST_IDLE;
          if (byte_done) begin
            pair_done = 1'b1;
          end else begin
            x_hold_nx = '0;
          end
        end else if (x_edge && byte_done) begin
          x_hold_nx = shift_data;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      x_hold <= '0;
    end else begin
      state  <= state_nx;
      x_hold <= x_hold_nx;
    end
  end

  assign new_pair.x = x_hold;
  assign new_pair.y = shift_data;

  logic pair_keep, pair_drop;
  assign pair_keep = pair_done & ~bus.pen_irq_n;
  assign pair_drop = pair_done &  bus.pen_irq_n;

  // ---------------- optional averaging ----------------
  logic      deliver;
  pos_pair_t out_pair;

`ifdef TOUCH_AVG_EN
  logic [AVG_SHIFT-1:0] pair_cnt;
  logic [SUM_W-1:0]     sum_x, sum_y;
  logic [SUM_W-1:0]     sum_x_nx, sum_y_nx;
  logic                 last_pair;

  assign sum_x_nx  = sum_x + SUM_W'(new_pair.x);
  assign sum_y_nx  = sum_y + SUM_W'(new_pair.y);
  assign last_pair = (pair_cnt == AVG_SHIFT'(AVG_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      sum_x    <= '0;
      sum_y    <= '0;
    end else if (pair_drop || (pair_keep && last_pair)) begin
      // Pen-up restarts the window; a full window is reported and cleared.
      pair_cnt <= '0;
      sum_x    <= '0;
      sum_y    <= '0;
    end else if (pair_keep) begin
      pair_cnt <= pair_cnt + AVG_SHIFT'(1);
      sum_x    <= sum_x_nx;
      sum_y    <= sum_y_nx;
    end
  end

  assign deliver    = pair_keep & last_pair;
  assign out_pair.x = avg_of(sum_x_nx);
  assign out_pair.y = avg_of(sum_y_nx);
`else
  assign deliver  = pair_keep;
  assign out_pair = new_pair;
`endif

  // ---------------- output register and handshake ----------------
  sample_t x_pos_q, y_pos_q;
  logic    pos_valid_q, overrun_q;
  logic    accept, can_load;

  assign accept   = pos_valid_q & bus.pos_ready;
  assign can_load = ~pos_valid_q | bus.pos_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      pos_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (deliver && can_load) begin
        x_pos_q     <= out_pair.x;
        y_pos_q     <= out_pair.y;
        pos_valid_q <= 1'b1;
      end else if (accept) begin
        pos_valid_q <= 1'b0;
      end

      if (deliver && !can_load) begin
        overrun_q <= 1'b1;
      end else if (accept) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.x_pos     = x_pos_q;
  assign bus.y_pos     = y_pos_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_touch_sample_capture.sv
// Directed self-checking bench for touch_sample_capture; expected pairs are
// queued when stimulus is driven and popped by a monitor on each transfer.
module tb_touch_sample_capture;
  import touch_sample_capture_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  touch_sample_capture_if bus();

  touch_sample_capture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int        total        = 0;
  int        bad          = 0;
  int        valid_cycles = 0;
  int        accepts      = 0;
  int        a0;
  pos_pair_t sb[$];
  pos_pair_t mon_exp;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, a transfer happens at the next rise.
  always @(negedge clk) begin
    if (rst_n && bus.pos_valid === 1'b1) begin
      valid_cycles++;
      if (bus.pos_ready === 1'b1) begin
        accepts++;
        if (sb.size() == 0) begin
          check("unexpected_pair", 16'(sb.size()), 16'd1);
        end else begin
          mon_exp = sb.pop_front();
          check("pair", {bus.x_pos, bus.y_pos}, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tick();
      bus.en  = 1'b1;
      bus.din = v[i];
    end
    tick();
    bus.en  = 1'b0;
    bus.din = 1'b0;
  endtask

  task automatic send_byte(input sample_t b);
    send_bits(16'(b), 8);
  endtask

  task automatic pulse(input logic px, input logic py);
    tick();
    bus.x_strobe = px;
    bus.y_strobe = py;
    tick();
    bus.x_strobe = 1'b0;
    bus.y_strobe = 1'b0;
  endtask

  task automatic send_pair(input sample_t x, input sample_t y);
    send_byte(x);
    pulse(1'b1, 1'b0);
    send_byte(y);
    pulse(1'b0, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.pos_valid === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 16'(sb.size()), 16'd0);
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.din       = 1'b0;
    bus.x_strobe  = 1'b0;
    bus.y_strobe  = 1'b0;
    bus.pen_irq_n = 1'b1;
    bus.pos_ready = 1'b0;
    rst_n         = 1'b0;

    repeat (3) tick();
    check("rst_x_pos",     16'(bus.x_pos),     16'h00);
    check("rst_y_pos",     16'(bus.y_pos),     16'h00);
    check("rst_pos_valid", 16'(bus.pos_valid), 16'h0);
    check("rst_overrun",   16'(bus.overrun),   16'h0);
    rst_n = 1'b1;
    tick();

`ifdef TOUCH_AVG_EN
    bus.pen_irq_n = 1'b0;
    bus.pos_ready = 1'b1;
    send_pair(8'h10, 8'h80);
    send_pair(8'h20, 8'h80);
    send_pair(8'h30, 8'h80);
    check("avg_no_early_output", 16'(accepts), 16'd0);
    sb.push_back('{x: 8'h28, y: 8'h80});
    send_pair(8'h40, 8'h80);
    wait_drain("avg_drain_1");
    check("avg_one_output", 16'(accepts), 16'd1);

    // A pen-up pair must throw away the partially filled window.
    send_pair(8'hFF, 8'hFF);
    bus.pen_irq_n = 1'b1;
    send_pair(8'h01, 8'h01);
    bus.pen_irq_n = 1'b0;
    sb.push_back('{x: 8'h04, y: 8'h08});
    repeat (4) send_pair(8'h04, 8'h08);
    wait_drain("avg_drain_2");
    check("avg_two_outputs", 16'(accepts), 16'd2);
`else
    // Basic pair, zero-latency load, single-cycle valid with ready held high.
    bus.pen_irq_n = 1'b0;
    bus.pos_ready = 1'b1;
    valid_cycles  = 0;
    sb.push_back('{x: 8'hA6, y: 8'h3C});
    send_byte(8'hA6);
    pulse(1'b1, 1'b0);
    send_byte(8'h3C);
    pulse(1'b0, 1'b1);
    check("latency_valid", 16'(bus.pos_valid), 16'h1);
    wait_drain("basic_drain");
    check("basic_valid_cycles", 16'(valid_cycles), 16'd1);

    // Short byte before x: nothing latched, following y is ignored in IDLE.
    a0 = accepts;
    send_bits(16'h001F, 5);
    pulse(1'b1, 1'b0);
    send_byte(8'h55);
    pulse(1'b0, 1'b1);
    repeat (10) tick();
    check("short_no_valid",   16'(bus.pos_valid), 16'h0);
    check("short_no_accepts", 16'(accepts - a0),  16'd0);

    // Two pairs with the consumer stalled: first held, second overruns.
    bus.pos_ready = 1'b0;
    sb.push_back('{x: 8'h11, y: 8'h22});
    send_pair(8'h11, 8'h22);
    check("stall_valid_1",   16'(bus.pos_valid), 16'h1);
    check("stall_overrun_1", 16'(bus.overrun),   16'h0);
    send_pair(8'h33, 8'h44);
    check("stall_overrun_2", 16'(bus.overrun),   16'h1);
    check("stall_x_held",    16'(bus.x_pos),     16'h11);
    check("stall_y_held",    16'(bus.y_pos),     16'h22);
    check("stall_valid_2",   16'(bus.pos_valid), 16'h1);
    bus.pos_ready = 1'b1;
    tick();
    check("accept_overrun_clr", 16'(bus.overrun),   16'h0);
    check("accept_valid_clr",   16'(bus.pos_valid), 16'h0);
    wait_drain("stall_drain");

    // Pen-up filter.
    a0 = accepts;
    bus.pen_irq_n = 1'b1;
    send_pair(8'h5A, 8'hA5);
    repeat (5) tick();
    check("penup_no_valid",   16'(bus.pos_valid), 16'h0);
    check("penup_no_overrun", 16'(bus.overrun),   16'h0);
    check("penup_no_accepts", 16'(accepts - a0),  16'd0);
    bus.pen_irq_n = 1'b0;

    // Reset in the middle of a byte.
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.en  = 1'b1;
      bus.din = 1'b1;
    end
    tick();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.din = 1'b0;
    tick();
    tick();
    check("midrst_x_pos", 16'(bus.x_pos), 16'h00);
    check("midrst_y_pos", 16'(bus.y_pos), 16'h00);
    rst_n = 1'b1;
    sb.push_back('{x: 8'h0F, y: 8'hF0});
    send_pair(8'h0F, 8'hF0);
    wait_drain("midrst_drain");

    // Coincident x and y edges in HAVE_X behave as y only.
    sb.push_back('{x: 8'h12, y: 8'h34});
    send_byte(8'h12);
    pulse(1'b1, 1'b0);
    send_byte(8'h34);
    pulse(1'b1, 1'b1);
    wait_drain("both_edges_drain");

    // A second x byte replaces the held one.
    sb.push_back('{x: 8'h02, y: 8'h03});
    send_byte(8'h01);
    pulse(1'b1, 1'b0);
    send_byte(8'h02);
    pulse(1'b1, 1'b0);
    send_byte(8'h03);
    pulse(1'b0, 1'b1);
    wait_drain("replace_drain");

    // Bits after the eighth are ignored.
    sb.push_back('{x: 8'hC3, y: 8'h99});
    send_bits(16'h030F, 10);
    pulse(1'b1, 1'b0);
    send_byte(8'h99);
    pulse(1'b0, 1'b1);
    wait_drain("extra_bits_drain");

    // y with an incomplete byte drops x; the next y lands in IDLE and is ignored.
    a0 = accepts;
    send_byte(8'h77);
    pulse(1'b1, 1'b0);
    send_bits(16'h0005, 3);
    pulse(1'b0, 1'b1);
    send_byte(8'h44);
    pulse(1'b0, 1'b1);
    repeat (8) tick();
    check("discard_no_valid",   16'(bus.pos_valid), 16'h0);
    check("discard_no_accepts", 16'(accepts - a0),  16'd0);
`endif

    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
